if_fetch_queue: RTL and testbench

Instruction fetch stage directly upstream of the decode/immediate-generation stage. Owns the fetch PC and issues one word request at a time to instruction memory. Buffers returned words with their PCs in a small FIFO, and presents the head word to decode as `id_instr`/`id_pc`. Supports a decode-side stall and a branch/jump redirect that flushes all buffered and in-flight fetches.

---
 rtl/if_fetch_queue.sv | 124 ++++++++++++
 tb/tb_if_fetch_queue.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC and issues one memory request at a time.
// Returned words are queued with their PCs and presented to decode from the FIFO head.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DROP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          accept;
    logic          push;
    logic          pop;
    logic          unused_redirect_bits;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign imem_req  = (state == REQ) && (count < DEPTH_C) && !redirect_valid && !rst;
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ready;
    // A response arriving in the redirect cycle belongs to the old stream, so it is never queued.
    assign push      = (state == WAIT) && imem_rvalid && !redirect_valid;

    assign id_valid  = (count != '0);
    assign pop       = id_valid && !id_stall && !redirect_valid;
    assign id_instr  = id_valid ? fifo_instr[rd_ptr] : NOP_INSTR;
    assign id_pc     = id_valid ? fifo_pc[rd_ptr] : 32'h0000_0000;

    always_comb begin
        state_next = state;
        case (state)
            REQ: begin
                if (accept) state_next = WAIT;
            end
            WAIT: begin
                if (imem_rvalid)         state_next = REQ;
                else if (redirect_valid) state_next = DROP;
            end
            DROP: begin
                if (imem_rvalid) state_next = REQ;
            end
            default: state_next = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= REQ;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_next;

            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else if (accept) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end

            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage needs no reset; entries are only observable once count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= req_pc;
            fifo_instr[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue: a queue-based reference model plus a memory with random latency,
// and a second instance that exercises fetch-PC wrap-around from 32'hFFFF_FFFC.
module tb_if_fetch_queue;

    localparam int          DEPTH     = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0040;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC   = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    logic        w_rst;
    logic        w_rvalid;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;

    int tests    = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      m_q[$];
    logic [31:0] m_fetch;
    logic [31:0] m_req_pc;
    bit          m_out;
    bit          m_stale;
    int          mem_delay;

    always #5 clk = ~clk;

    if_fetch_queue #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .NOP_INSTR(NOP_INSTR)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_stall      (id_stall),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc         (id_pc)
    );

    if_fetch_queue #(
        .RESET_PC (WRAP_PC),
        .DEPTH    (2),
        .NOP_INSTR(NOP_INSTR)
    ) u_wrap (
        .clk           (clk),
        .rst           (w_rst),
        .imem_req      (w_req),
        .imem_addr     (w_addr),
        .imem_ready    (1'b1),
        .imem_rvalid   (w_rvalid),
        .imem_rdata    (32'hDEAD_BEEF),
        .redirect_valid(1'b0),
        .redirect_pc   (32'h0000_0000),
        .id_stall      (1'b0),
        .id_valid      (w_valid),
        .id_instr      (w_instr),
        .id_pc         (w_pc)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_q.delete();
        m_fetch   = RESET_PC;
        m_req_pc  = RESET_PC;
        m_out     = 1'b0;
        m_stale   = 1'b0;
        mem_delay = 0;
    endtask

    // Random inputs; the memory answers an outstanding request after its drawn latency,
    // and occasionally raises a spurious rvalid when nothing is outstanding.
    task automatic applyStimulus(input int stall_pct, input int redirect_pct);
        rst            = ($urandom_range(0, 63) == 0);
        redirect_valid = ($urandom_range(0, 99) < redirect_pct);
        redirect_pc    = $urandom;
        id_stall       = ($urandom_range(0, 99) < stall_pct);
        imem_ready     = ($urandom_range(0, 3) != 0);
        if (m_out) begin
            imem_rvalid = (mem_delay == 0);
            imem_rdata  = imem_rvalid ? mem_data(m_req_pc) : $urandom;
        end else begin
            imem_rvalid = ($urandom_range(0, 7) == 0);
            imem_rdata  = $urandom;
        end
    endtask

    task automatic checkCycle();
        bit exp_req;
        exp_req = !rst && !redirect_valid && !m_out && (m_q.size() < DEPTH);
        checkOutput("imem_req", 32'(imem_req), 32'(exp_req));
        if (!rst && !m_out) checkOutput("imem_addr", imem_addr, m_fetch);
        checkOutput("id_valid", 32'(id_valid), 32'(m_q.size() > 0));
        checkOutput("id_instr", id_instr, (m_q.size() > 0) ? m_q[0].instr : NOP_INSTR);
        checkOutput("id_pc", id_pc, (m_q.size() > 0) ? m_q[0].pc : 32'h0000_0000);
    endtask

    task automatic stepModel();
        bit     was_out;
        bit     req;
        bit     pop;
        entry_t e;
        if (rst) begin
            modelReset();
            return;
        end
        was_out = m_out;
        req     = !redirect_valid && !m_out && (m_q.size() < DEPTH);
        pop     = (m_q.size() > 0) && !id_stall && !redirect_valid;
        if (redirect_valid) begin
            m_q.delete();
            m_fetch = {redirect_pc[31:2], 2'b00};
            if (m_out) begin
                if (imem_rvalid) begin
                    m_out   = 1'b0;
                    m_stale = 1'b0;
                end else begin
                    m_stale = 1'b1;
                end
            end
        end else begin
            if (pop) e = m_q.pop_front();
            if (m_out && imem_rvalid) begin
                if (!m_stale) begin
                    e.pc    = m_req_pc;
                    e.instr = imem_rdata;
                    m_q.push_back(e);
                end
                m_out   = 1'b0;
                m_stale = 1'b0;
            end else if (req && imem_ready) begin
                m_req_pc  = m_fetch;
                m_fetch   = m_fetch + 32'd4;
                m_out     = 1'b1;
                m_stale   = 1'b0;
                mem_delay = $urandom_range(0, 3);
            end
        end
        if (was_out && m_out && !imem_rvalid && mem_delay > 0) mem_delay--;
    endtask

    task automatic runPhase(input int cycles, input int stall_pct, input int redirect_pct);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            applyStimulus(stall_pct, redirect_pct);
            #1;
            checkCycle();
            stepModel();
        end
    endtask

    initial begin
        rst            = 1'b1;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0000_0000;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        id_stall       = 1'b0;
        w_rst          = 1'b1;
        w_rvalid       = 1'b0;
        modelReset();

        @(negedge clk);
        #1;
        checkOutput("rst_imem_req", 32'(imem_req), 32'h0);

        // Wrap instance: one fetch at 0xFFFF_FFFC, then the next request must be at 0.
        @(negedge clk);
        w_rst = 1'b0;
        #1;
        checkOutput("rst_imem_req", 32'(imem_req), 32'h0);
        checkOutput("wrap_req0", 32'(w_req), 32'h1);
        checkOutput("wrap_addr0", w_addr, WRAP_PC);
        @(negedge clk);
        w_rvalid = 1'b1;
        #1;
        checkOutput("wrap_req_wait", 32'(w_req), 32'h0);
        @(negedge clk);
        w_rvalid = 1'b0;
        #1;
        checkOutput("wrap_addr1", w_addr, 32'h0000_0000);
        checkOutput("wrap_req1", 32'(w_req), 32'h1);
        checkOutput("wrap_id_pc", w_pc, WRAP_PC);
        checkOutput("wrap_id_instr", w_instr, 32'hDEAD_BEEF);
        checkOutput("wrap_id_valid", 32'(w_valid), 32'h1);

        // First cycle out of reset: idle decode side and fetch about to start at RESET_PC.
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_id_valid", 32'(id_valid), 32'h0);
        checkOutput("reset_id_instr", id_instr, NOP_INSTR);
        checkOutput("reset_id_pc", id_pc, 32'h0000_0000);
        checkOutput("reset_imem_addr", imem_addr, RESET_PC);
        checkOutput("reset_imem_req", 32'(imem_req), 32'h1);
        stepModel();

        runPhase(1000, 30, 8);
        runPhase(800, 90, 4);
        runPhase(800, 0, 15);
        runPhase(600, 50, 30);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
